// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and RAW/WAW hazard scoreboard for a 2R/1W register file.
// Latency: a write-back handshake at edge N drives reg_write/write_reg/write_data in cycle N+1.
// Backpressure: one source gets ready per cycle (round-robin); decode holds while stall is high.
module regfile_wb_sched #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_REGS  = 32,
    parameter bit ALU_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    // decode / issue side
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_rd,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    output logic                stall,
    // ALU write-back source
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    // load-unit write-back source
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    // register-file write port
    output logic                reg_write,
    output logic [ADDR_W-1:0]   write_reg,
    output logic [DATA_W-1:0]   write_data,
    // scoreboard status
    output logic [NUM_REGS-1:0] pend_bits,
    output logic                err_spur
);

    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_write_reg;
    logic [DATA_W-1:0]   r_write_data;
    logic [NUM_REGS-1:0] r_pend;
    logic                r_err_spur;
    logic                r_last_mem;   // 1: last handshake went to the load unit

    logic                w_grant_mem;
    logic                w_hs;
    logic [ADDR_W-1:0]   w_hs_rd;
    logic [DATA_W-1:0]   w_hs_data;
    logic                w_issue_ok;
    logic [NUM_REGS-1:0] w_pend_nxt;

    // Index 0 and indices beyond the bitmap never read as pending.
    function automatic logic f_pend(input logic [ADDR_W-1:0] idx,
                                    input logic [NUM_REGS-1:0] bits);
        f_pend = (idx != '0) && (int'(idx) < NUM_REGS) && bits[idx];
    endfunction

    // Round-robin grant: load unit wins when alone, or on a tie when the ALU went last.
    always_comb begin
        w_grant_mem = mem_valid & (~alu_valid | ~r_last_mem);
        alu_ready   = rst_n & alu_valid & ~w_grant_mem;
        mem_ready   = rst_n & w_grant_mem;
        w_hs        = alu_ready | mem_ready;
        w_hs_rd     = w_grant_mem ? mem_rd   : alu_rd;
        w_hs_data   = w_grant_mem ? mem_data : alu_data;
    end

    // Hazard detect: a committing register still counts as pending this cycle.
    always_comb begin
        stall = f_pend(rs1, r_pend) | f_pend(rs2, r_pend)
              | (iss_valid & f_pend(iss_rd, r_pend));
        w_issue_ok = iss_valid & ~stall;
    end

    // Next bitmap: clear the committing register, then a new producer re-sets it.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_reg_write && int'(r_write_reg) < NUM_REGS) begin
            w_pend_nxt[r_write_reg] = 1'b0;
        end
        if (w_issue_ok && iss_rd != '0 && int'(iss_rd) < NUM_REGS) begin
            w_pend_nxt[iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Write port, arbitration history, scoreboard and spurious-commit flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_pend       <= '0;
            r_err_spur   <= 1'b0;
            r_last_mem   <= ALU_FIRST;
        end else begin
            r_pend     <= w_pend_nxt;
            r_err_spur <= r_reg_write & ~f_pend(r_write_reg, r_pend);
            if (w_hs) begin
                r_last_mem <= w_grant_mem;
            end
            // x0 writes are consumed but never reach the file; index/data hold.
            if (w_hs && w_hs_rd != '0) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= w_hs_rd;
                r_write_data <= w_hs_data;
            end else begin
                r_reg_write  <= 1'b0;
            end
        end
    end

    assign reg_write  = r_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign pend_bits  = r_pend;
    assign err_spur   = r_err_spur;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: vector table plus a mid-stream reset sequence.
// Inputs change on the falling edge; outputs are sampled 1 ns before the rising edge.
// Expected values are hand-computed constants in the table rows.
module tb_regfile_wb_sched;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    localparam logic [31:0] A3  = 32'hA000_0003;
    localparam logic [31:0] M4  = 32'hB000_0004;
    localparam logic [31:0] A5  = 32'hA000_0005;
    localparam logic [31:0] A7  = 32'hA000_0007;
    localparam logic [31:0] A9  = 32'hA000_0009;
    localparam logic [31:0] A10 = 32'hA000_000A;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iss_valid;
    logic [AW-1:0] iss_rd, rs1, rs2;
    logic          stall;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [NR-1:0] pend_bits;
    logic          err_spur;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_sched #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ALU_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .pend_bits(pend_bits), .err_spur(err_spur)
    );

    typedef struct {
        logic          rst;
        logic          iv;
        logic [AW-1:0] ird, r1, r2;
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] adat;
        logic          mv;
        logic [AW-1:0] mrd;
        logic [DW-1:0] mdat;
        logic          e_stall, e_ar, e_mr, e_rw;
        logic [AW-1:0] e_wr;
        logic [DW-1:0] e_wd;
        logic [NR-1:0] e_pend;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic iv, input int ird, input int r1, input int r2,
                       input logic av, input int ard, input logic [DW-1:0] adat,
                       input logic mv, input int mrd, input logic [DW-1:0] mdat,
                       input logic es, input logic ear, input logic emr, input logic erw,
                       input int ewr, input logic [DW-1:0] ewd, input logic [NR-1:0] ep,
                       input logic eerr);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ird = AW'(ird); v.r1 = AW'(r1); v.r2 = AW'(r2);
        v.av = av; v.ard = AW'(ard); v.adat = adat;
        v.mv = mv; v.mrd = AW'(mrd); v.mdat = mdat;
        v.e_stall = es; v.e_ar = ear; v.e_mr = emr; v.e_rw = erw;
        v.e_wr = AW'(ewr); v.e_wd = ewd; v.e_pend = ep; v.e_err = eerr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst; iss_valid = v.iv; iss_rd = v.ird; rs1 = v.r1; rs2 = v.r2;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdat;
    endtask

    task automatic check_all(input int row, input vec_t v);
        chk("stall",      row, 32'(stall),      32'(v.e_stall));
        chk("alu_ready",  row, 32'(alu_ready),  32'(v.e_ar));
        chk("mem_ready",  row, 32'(mem_ready),  32'(v.e_mr));
        chk("reg_write",  row, 32'(reg_write),  32'(v.e_rw));
        chk("write_reg",  row, 32'(write_reg),  32'(v.e_wr));
        chk("write_data", row, write_data,      v.e_wd);
        chk("pend_bits",  row, pend_bits,       v.e_pend);
        chk("err_spur",   row, 32'(err_spur),   32'(v.e_err));
    endtask

    // Apply one vector at the falling edge, sample just before the rising edge.
    task automatic step(input int row, input vec_t v);
        @(negedge clk);
        drive(v);
        #4;
        check_all(row, v);
    endtask

    initial begin
        vec_t idle;
        idle = '{default: '0};
        idle.rst = 1'b1;
        drive(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        //   rst iv ird r1 r2  av ard adat  mv mrd mdat | stall ar mr rw wr wd  pend  err
        // reset with both sources requesting: no grants, everything cleared
        add(0, 0, 0, 0, 0,  1, 3, A3,  1, 4, M4,   0, 0, 0, 0, 0, 0,  32'h0, 0);
        // round-robin ALU,MEM,ALU,MEM; each commit is one cycle later (all spurious)
        add(1, 0, 0, 0, 0,  1, 3, A3,  1, 4, M4,   0, 1, 0, 0, 0, 0,  32'h0, 0);
        add(1, 0, 0, 0, 0,  1, 3, A3,  1, 4, M4,   0, 0, 1, 1, 3, A3, 32'h0, 0);
        add(1, 0, 0, 0, 0,  1, 3, A3,  1, 4, M4,   0, 1, 0, 1, 4, M4, 32'h0, 1);
        add(1, 0, 0, 0, 0,  1, 3, A3,  1, 4, M4,   0, 0, 1, 1, 3, A3, 32'h0, 1);
        add(1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 4, M4, 32'h0, 1);
        add(1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 4, M4, 32'h0, 1);
        // issue x5, then a reader of x5 stalls until the cycle after x5 commits
        add(1, 1, 5, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 4, M4, 32'h0, 0);
        add(1, 1, 6, 5, 0,  1, 5, A5,  0, 0, 0,    1, 1, 0, 0, 4, M4, 32'h20, 0);
        add(1, 1, 6, 5, 0,  0, 0, 0,   0, 0, 0,    1, 0, 0, 1, 5, A5, 32'h20, 0);
        add(1, 1, 6, 5, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 5, A5, 32'h0, 0);
        // x7 written while not pending; issue x7 during that commit: set wins
        add(1, 0, 0, 0, 0,  1, 7, A7,  0, 0, 0,    0, 1, 0, 0, 5, A5, 32'h40, 0);
        add(1, 1, 7, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 7, A7, 32'h40, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 7, A7, 32'hC0, 1);
        // load to x0: accepted, never written, port registers hold
        add(1, 0, 0, 0, 0,  0, 0, 0,   1, 0, DB,   0, 0, 1, 0, 7, A7, 32'hC0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 7, A7, 32'hC0, 0);
        // ALU write to non-pending x9: written, err_spur one pulse
        add(1, 0, 0, 0, 0,  1, 9, A9,  0, 0, 0,    0, 1, 0, 0, 7, A7, 32'hC0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 1, 9, A9, 32'hC0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 9, A9, 32'hC0, 1);
        add(1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 9, A9, 32'hC0, 0);
        // WAW stall on x6, RAW stall via rs2 on x7, x0 never stalls
        add(1, 1, 6, 0, 0,  0, 0, 0,   0, 0, 0,    1, 0, 0, 0, 9, A9, 32'hC0, 0);
        add(1, 0, 0, 0, 7,  0, 0, 0,   0, 0, 0,    1, 0, 0, 0, 9, A9, 32'hC0, 0);
        add(1, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0,    0, 0, 0, 0, 9, A9, 32'hC0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(i, tbl[i]);
        end

        // Mid-stream reset: an accepted ALU write to x10 is dropped, and the
        // tie-break restarts with the ALU even though the ALU went last.
        @(negedge clk);
        drive(idle);
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = A10;
        #4;
        chk("pre_rst_alu_ready", 100, 32'(alu_ready), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        rst_n = 1'b0;
        #4;
        chk("pre_rst_reg_write", 101, 32'(reg_write), 32'd1);
        chk("pre_rst_write_reg", 101, 32'(write_reg), 32'd10);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = A3;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = M4;
        #4;
        chk("rst_alu_ready",  102, 32'(alu_ready), 32'd0);
        chk("rst_mem_ready",  102, 32'(mem_ready), 32'd0);
        chk("rst_reg_write",  102, 32'(reg_write), 32'd0);
        chk("rst_write_reg",  102, 32'(write_reg), 32'd0);
        chk("rst_write_data", 102, write_data,     32'd0);
        chk("rst_pend_bits",  102, pend_bits,      32'd0);
        chk("rst_err_spur",   102, 32'(err_spur),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        chk("post_rst_alu_ready", 103, 32'(alu_ready), 32'd1);
        chk("post_rst_mem_ready", 103, 32'(mem_ready), 32'd0);
        @(negedge clk);
        drive(idle);
        #4;
        chk("post_rst_reg_write", 104, 32'(reg_write), 32'd1);
        chk("post_rst_write_reg", 104, 32'(write_reg), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
